uart_tx_controller: RTL

- Transmit-side sequencer for the UART link.
- Accepts a byte plus a baud selection from the host over a write handshake.
- Drives and holds the baud selection into baud_controller for the whole frame.
- Counts that block's sample_ENABLE ticks, OVERSAMPLE per bit, and serialises start, data (LSB first), optional parity and stop bits onto TxD.

---
 rtl/uart_tx_controller_if.sv | 21 ++
 rtl/uart_tx_controller.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_controller_if.sv
// rtl/uart_tx_controller_if.sv - host write handshake and status between host and uart_tx_controller
interface uart_tx_controller_if #(
  parameter int DATA_W = 8
);
  logic              Tx_EN;
  logic              Tx_WR;
  logic [DATA_W-1:0] Tx_DATA;
  logic [2:0]        baud_select;
  logic              Tx_BUSY;
  logic              Tx_DONE;

  modport master (
    output Tx_EN, Tx_WR, Tx_DATA, baud_select,
    input  Tx_BUSY, Tx_DONE
  );

  modport slave (
    input  Tx_EN, Tx_WR, Tx_DATA, baud_select,
    output Tx_BUSY, Tx_DONE
  );
endinterface

// File: rtl/uart_tx_controller.sv
// rtl/uart_tx_controller.sv - UART transmit sequencer: start, LSB-first data, optional parity, stop
// Optional even parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_controller #(
  parameter int         DATA_W       = 8,
  parameter int         OVERSAMPLE   = 16,
  parameter logic [2:0] DEFAULT_BAUD = 3'b111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_ENABLE,
  uart_tx_controller_if.slave host,
  output logic [2:0]          baud_sel_out,
  output logic                TxD
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [2:0]          baud_q, baud_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_end = sample_ENABLE && (tick_q == TICK_W'(OVERSAMPLE - 1));

    // Ticks only count once a frame is under way; the acceptance cycle's tick is dropped.
    if (state_q != S_IDLE && sample_ENABLE) begin
      tick_d = bit_end ? '0 : tick_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (host.Tx_EN && host.Tx_WR) begin
          shift_d = host.Tx_DATA;
          baud_d  = host.baud_select;
          tick_d  = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^host.Tx_DATA;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so TxD stays a plain register.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      baud_q  <= DEFAULT_BAUD;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TxD          = txd_q;
  assign baud_sel_out = baud_q;
  assign host.Tx_BUSY = busy_q;
  assign host.Tx_DONE = done_q;

endmodule
